// File: rtl/bpred_resolve_queue.sv
// rtl/bpred_resolve_queue.sv - branch snapshot queue that turns in-order resolves into bpredictor update pulses
// A mispredicted pop flushes every younger snapshot so fetch restarts from an empty queue.
module bpred_resolve_queue #(
  parameter int DEPTH     = 8,
  parameter int BIMODAL_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 soin_bpredictor_stall,
  input  logic                 fetch_push,
  input  logic                 bpredictor_fetch_p_dir,
  input  logic [BIMODAL_W-1:0] bpredictor_fetch_bimodal,
  input  logic [31:0]          fetch_pred_target,
  output logic                 fetch_full,
  input  logic                 resolve_valid,
  input  logic [31:0]          resolve_PC4,
  input  logic                 resolve_taken,
  input  logic [31:0]          resolve_target,
  output logic                 execute_bpredictor_update,
  output logic [31:0]          execute_bpredictor_PC4,
  output logic [31:0]          execute_bpredictor_target,
  output logic                 execute_bpredictor_dir,
  output logic                 execute_bpredictor_miss,
  output logic [BIMODAL_W-1:0] execute_bpredictor_bimodal,
  output logic [31:0]          execute_redirect_pc,
  output logic                 resolve_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic                 dir_mem [DEPTH];
  logic [BIMODAL_W-1:0] bim_mem [DEPTH];
  logic [31:0]          tgt_mem [DEPTH];

  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W:0]       count;

  logic                 head_dir;
  logic [BIMODAL_W-1:0] head_bim;
  logic [31:0]          head_tgt;
  logic                 queue_empty;
  logic                 pop;
  logic                 miss;
  logic                 push_ok;

  assign head_dir    = dir_mem[rd_ptr];
  assign head_bim    = bim_mem[rd_ptr];
  assign head_tgt    = tgt_mem[rd_ptr];
  assign queue_empty = (count == '0);
  assign fetch_full  = (count == FULL_CNT);

  // A resolve on an empty queue is an underflow, never a pass-through of a same-cycle push.
  assign pop  = resolve_valid && !queue_empty;
  assign miss = pop && ((head_dir != resolve_taken) ||
                        (resolve_taken && (head_tgt != resolve_target)));

  // A pop frees a slot in the same cycle, so a full queue still accepts when it drains.
  assign push_ok = fetch_push && !soin_bpredictor_stall && !miss &&
                   (!fetch_full || pop);

  // Snapshot storage needs no reset: entries are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      dir_mem[wr_ptr] <= bpredictor_fetch_p_dir;
      bim_mem[wr_ptr] <= bpredictor_fetch_bimodal;
      tgt_mem[wr_ptr] <= fetch_pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      execute_bpredictor_update  <= 1'b0;
      execute_bpredictor_miss    <= 1'b0;
      execute_bpredictor_PC4     <= '0;
      execute_bpredictor_target  <= '0;
      execute_bpredictor_dir     <= 1'b0;
      execute_bpredictor_bimodal <= '0;
      execute_redirect_pc        <= '0;
      resolve_underflow          <= 1'b0;
    end else begin
      execute_bpredictor_update <= pop;
      execute_bpredictor_miss   <= miss;
      if (pop) begin
        execute_bpredictor_PC4     <= resolve_PC4;
        execute_bpredictor_target  <= resolve_target;
        execute_bpredictor_dir     <= resolve_taken;
        execute_bpredictor_bimodal <= head_bim;
        execute_redirect_pc        <= resolve_taken ? resolve_target : resolve_PC4;
      end
      if (resolve_valid && queue_empty) resolve_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// tb/tb_bpred_resolve_queue.sv - scoreboard bench for bpred_resolve_queue
module tb_bpred_resolve_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic        dir;
    logic [11:0] bim;
    logic [31:0] tgt;
  } snap_t;

  typedef struct packed {
    logic        upd;
    logic        miss;
    logic        dir;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic [11:0] bim;
    logic [31:0] redir;
    logic        unf;
    logic        full;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        soin_bpredictor_stall;
  logic        fetch_push;
  logic        bpredictor_fetch_p_dir;
  logic [11:0] bpredictor_fetch_bimodal;
  logic [31:0] fetch_pred_target;
  logic        fetch_full;
  logic        resolve_valid;
  logic [31:0] resolve_PC4;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        execute_bpredictor_update;
  logic [31:0] execute_bpredictor_PC4;
  logic [31:0] execute_bpredictor_target;
  logic        execute_bpredictor_dir;
  logic        execute_bpredictor_miss;
  logic [11:0] execute_bpredictor_bimodal;
  logic [31:0] execute_redirect_pc;
  logic        resolve_underflow;

  bpred_resolve_queue #(.DEPTH(DEPTH), .BIMODAL_W(12)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .soin_bpredictor_stall      (soin_bpredictor_stall),
    .fetch_push                 (fetch_push),
    .bpredictor_fetch_p_dir     (bpredictor_fetch_p_dir),
    .bpredictor_fetch_bimodal   (bpredictor_fetch_bimodal),
    .fetch_pred_target          (fetch_pred_target),
    .fetch_full                 (fetch_full),
    .resolve_valid              (resolve_valid),
    .resolve_PC4                (resolve_PC4),
    .resolve_taken              (resolve_taken),
    .resolve_target             (resolve_target),
    .execute_bpredictor_update  (execute_bpredictor_update),
    .execute_bpredictor_PC4     (execute_bpredictor_PC4),
    .execute_bpredictor_target  (execute_bpredictor_target),
    .execute_bpredictor_dir     (execute_bpredictor_dir),
    .execute_bpredictor_miss    (execute_bpredictor_miss),
    .execute_bpredictor_bimodal (execute_bpredictor_bimodal),
    .execute_redirect_pc        (execute_redirect_pc),
    .resolve_underflow          (resolve_underflow)
  );

  obs_t act;
  assign act = {execute_bpredictor_update, execute_bpredictor_miss, execute_bpredictor_dir,
                execute_bpredictor_PC4, execute_bpredictor_target, execute_bpredictor_bimodal,
                execute_redirect_pc, resolve_underflow, fetch_full};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  snap_t mq[$];
  obs_t  exp_q[$];
  logic        m_dir, m_unf;
  logic [31:0] m_pc4, m_tgt, m_redir;
  logic [11:0] m_bim;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_dir = 0; m_unf = 0; m_pc4 = 0; m_tgt = 0; m_redir = 0; m_bim = 0;
  endtask

  // Drives one cycle of stimulus and queues the expected post-edge observation.
  task automatic drive_cycle(input logic push, input logic stall, input logic dir,
                             input logic [11:0] bim, input logic [31:0] tgt,
                             input logic rv, input logic [31:0] pc4,
                             input logic taken, input logic [31:0] rtgt);
    snap_t h, s;
    logic  pop, mis, acc;
    obs_t  e;
    fetch_push = push; soin_bpredictor_stall = stall; bpredictor_fetch_p_dir = dir;
    bpredictor_fetch_bimodal = bim; fetch_pred_target = tgt;
    resolve_valid = rv; resolve_PC4 = pc4; resolve_taken = taken; resolve_target = rtgt;
    h   = '0;
    pop = rv && (mq.size() != 0);
    mis = 1'b0;
    if (pop) begin
      h   = mq[0];
      mis = (h.dir != taken) || (taken && (h.tgt != rtgt));
    end
    if (rv && mq.size() == 0) m_unf = 1'b1;
    acc = push && !stall && !mis && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      h = mq.pop_front();
      m_dir = taken; m_pc4 = pc4; m_tgt = rtgt; m_bim = h.bim;
      m_redir = taken ? rtgt : pc4;
    end
    if (mis) mq.delete();
    if (acc) begin
      s.dir = dir; s.bim = bim; s.tgt = tgt;
      mq.push_back(s);
    end
    e = {pop, mis, m_dir, m_pc4, m_tgt, m_bim, m_redir, m_unf, (mq.size() == DEPTH)};
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b0;
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    checks++;
    if (act !== '0) $display("FAIL reset_state act=%h exp=0", act); else passed++;
    reset = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL reset_idle act=%h exp=%h", act, e); else passed++;
  endtask

  task automatic test_hit();
    obs_t e;
    drive_cycle(1, 0, 1, 12'd3, 32'h0, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL hit_push act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'd128, 1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL hit_update act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL hit_idle act=%h exp=%h", act, e); else passed++;
  endtask

  task automatic test_target_miss();
    obs_t e;
    drive_cycle(1, 0, 1, 12'h011, 32'h20, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL tgt_push act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h1C, 1, 32'h24);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL tgt_miss act=%h exp=%h", act, e); else passed++;
    drive_cycle(1, 0, 1, 12'h022, 32'h50, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL nt_push act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h88, 0, 32'h99);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL nt_miss act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL miss_idle act=%h exp=%h", act, e); else passed++;
  endtask

  task automatic test_stall();
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 0, 1, 12'h031 + 12'(i), 32'h300 + 32'(i * 16), 0, 0, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL stall_fill act=%h exp=%h", act, e); else passed++;
    end
    drive_cycle(1, 1, 1, 12'h033, 32'h320, 1, 32'h2FC, 1, 32'h300);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL stall_pop act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h30C, 1, 32'h310);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL stall_drain act=%h exp=%h", act, e); else passed++;
  endtask

  task automatic test_full_wrap();
    obs_t e;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1, 0, 1, 12'h100 + 12'(i), 32'h1000 + 32'(i), 0, 0, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL fill[%0d] act=%h exp=%h", i, act, e); else passed++;
    end
    drive_cycle(1, 0, 1, 12'h1FF, 32'hDEAD, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL full_drop act=%h exp=%h", act, e); else passed++;
    drive_cycle(1, 0, 1, 12'h108, 32'h1008, 1, 32'h2000, 1, 32'h1000);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL full_pop_push act=%h exp=%h", act, e); else passed++;
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 1, 32'h2000 + 32'(i * 4), 1, 32'h1000 + 32'(i));
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL drain[%0d] act=%h exp=%h", i, act, e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 0, 12'h040 + 12'(i), 32'h0, 0, 0, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL b2b_push act=%h exp=%h", act, e); else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 1, 32'h500 + 32'(i * 4), 0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL b2b_pulse[%0d] act=%h exp=%h", i, act, e); else passed++;
    end
  endtask

  task automatic test_dir_miss();
    obs_t e;
    drive_cycle(1, 0, 0, 12'h05A, 32'h0, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL dm_push act=%h exp=%h", act, e); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 1, 12'h05B + 12'(i), 32'h70, 0, 0, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL dm_younger act=%h exp=%h", act, e); else passed++;
    end
    drive_cycle(1, 0, 1, 12'h077, 32'h80, 1, 32'h40, 1, 32'h100);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL dir_miss act=%h exp=%h", act, e); else passed++;
    drive_cycle(1, 0, 1, 12'h066, 32'h600, 1, 32'h44, 1, 32'h80);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL underflow act=%h exp=%h", act, e); else passed++;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h48, 1, 32'h600);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL post_underflow act=%h exp=%h", act, e); else passed++;
  endtask

  task automatic test_reset_midop();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 0, 1, 12'h0A0 + 12'(i), 32'h900, 0, 0, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (act !== e) $display("FAIL mid_fill act=%h exp=%h", act, e); else passed++;
    end
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h804, 1, 32'h900);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL mid_pop act=%h exp=%h", act, e); else passed++;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act !== '0) $display("FAIL reset_async act=%h exp=0", act); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h904, 1, 32'h900);
    e = exp_q.pop_front(); checks++;
    if (act !== e) $display("FAIL reset_underflow act=%h exp=%h", act, e); else passed++;
  endtask

  initial begin
    reset = 1'b0;
    soin_bpredictor_stall = 0; fetch_push = 0; bpredictor_fetch_p_dir = 0;
    bpredictor_fetch_bimodal = 0; fetch_pred_target = 0;
    resolve_valid = 0; resolve_PC4 = 0; resolve_taken = 0; resolve_target = 0;
    model_reset();
    test_reset();
    test_hit();
    test_target_miss();
    test_stall();
    test_full_wrap();
    test_back_to_back();
    test_dir_miss();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
